// File: rtl/sysid_checker.sv
// Boot-time Avalon-MM read master that fetches the system-ID and timestamp words
// and compares them against the values fixed at build time.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd1114575596,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1224570194,
    parameter logic [15:0] MAX_WAIT           = 16'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ID,
        RD_TS,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] waitCnt_q, waitCnt_d;
    logic        idOk_q, idOk_d;
    logic        tsOk_q, tsOk_d;
    logic        timeout_q, timeout_d;
    logic [31:0] idValue_q, idValue_d;
    logic [31:0] tsValue_q, tsValue_d;
    logic        read_q, read_d;
    logic        address_q, address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        stallLimit;

    // True on the stalled cycle that would bring the wait counter up to MAX_WAIT.
    assign stallLimit = avm_waitrequest &&
                        (({1'b0, waitCnt_q} + 17'd1) == {1'b0, MAX_WAIT});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            idOk_q    <= 1'b0;
            tsOk_q    <= 1'b0;
            timeout_q <= 1'b0;
            idValue_q <= '0;
            tsValue_q <= '0;
            read_q    <= 1'b0;
            address_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            idOk_q    <= idOk_d;
            tsOk_q    <= tsOk_d;
            timeout_q <= timeout_d;
            idValue_q <= idValue_d;
            tsValue_q <= tsValue_d;
            read_q    <= read_d;
            address_q <= address_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        idOk_d    = idOk_q;
        tsOk_d    = tsOk_q;
        timeout_d = timeout_q;
        idValue_d = idValue_q;
        tsValue_d = tsValue_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RD_ID;
                    waitCnt_d = '0;
                    idOk_d    = 1'b0;
                    tsOk_d    = 1'b0;
                    timeout_d = 1'b0;
                    idValue_d = '0;
                    tsValue_d = '0;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    idValue_d = avm_readdata;
                    idOk_d    = (avm_readdata == EXPECTED_ID);
                    waitCnt_d = '0;
                    state_d   = RD_TS;
                end else if (stallLimit) begin
                    waitCnt_d = waitCnt_q + 16'd1;
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    tsValue_d = avm_readdata;
                    tsOk_d    = (avm_readdata == EXPECTED_TIMESTAMP);
                    waitCnt_d = '0;
                    state_d   = FINISH;
                end else if (stallLimit) begin
                    waitCnt_d = waitCnt_q + 16'd1;
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus and status outputs are registered from the upcoming state.
        read_d    = (state_d == RD_ID) || (state_d == RD_TS);
        address_d = (state_d == RD_TS);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FINISH);
    end

    assign avm_read    = read_q;
    assign avm_address = address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = idOk_q;
    assign ts_ok       = tsOk_q;
    assign timeout     = timeout_q;
    assign id_value    = idValue_q;
    assign ts_value    = tsValue_q;

endmodule
